// File: rtl/cpu_irq_pkg.sv
// Shared definitions for the cpu interrupt controller: FSM encoding and the
// default vector layout that the cpu control unit expects.
package cpu_irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

    localparam int unsigned VEC_BASE_DEF   = 32'h3C0;
    localparam int unsigned VEC_STRIDE_DEF = 32'd4;

    // Handler address of a channel; callers truncate to the PC width.
    function automatic int unsigned vecAddr(input int unsigned base,
                                            input int unsigned stride,
                                            input int unsigned chan);
        return base + stride * chan;
    endfunction

endpackage

// File: rtl/cpu_irq_arb.sv
// Combinational channel picker: fixed priority (index 0 first) or
// round-robin scanning upward from a pointer with wrap-around.
module cpu_irq_arb #(
    parameter int NCH   = 4,
    parameter int IDX_W = 2
) (
    input  logic [NCH-1:0]   eligible_i,
    input  logic [IDX_W-1:0] rrPtr_i,
    input  logic             mode_i,
    output logic [IDX_W-1:0] winner_o,
    output logic             valid_o
);

    logic [2*NCH-1:0] doubled;
    logic [NCH-1:0]   rotated;
    int               start;
    int               idx;

    // Rotate the request vector so the scan start sits at bit 0, then take
    // the lowest set bit; the descending loop leaves the lowest hit last.
    always_comb begin
        start    = mode_i ? int'(rrPtr_i) : 0;
        doubled  = {eligible_i, eligible_i} >> start;
        rotated  = doubled[NCH-1:0];
        winner_o = '0;
        valid_o  = 1'b0;
        idx      = 0;
        for (int off = NCH - 1; off >= 0; off--) begin
            if (rotated[off]) begin
                idx = start + off;
                if (idx >= NCH) begin
                    idx = idx - NCH;
                end
                winner_o = IDX_W'(idx);
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_irq_ctrl.sv
// Interrupt controller: per-channel edge capture, pending/overflow latches,
// software mask, and a request/ack/eoi handshake towards the cpu.
module cpu_irq_ctrl
    import cpu_irq_pkg::*;
#(
    parameter int          NCH         = 4,
    parameter int          PC_W        = 10,
    parameter int unsigned VEC_BASE    = VEC_BASE_DEF,
    parameter int unsigned VEC_STRIDE  = VEC_STRIDE_DEF,
    parameter int          RR_MODE     = 0,
    parameter int          SYNC_STAGES = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NCH-1:0]  irq_in,
    input  logic            mask_we,
    input  logic [NCH-1:0]  mask_wdata,
    output logic [NCH-1:0]  mask_q,
    output logic [NCH-1:0]  pending_q,
    output logic [NCH-1:0]  ovf_q,
    output logic            irq_req,
    output logic [PC_W-1:0] irq_vec,
    input  logic            irq_ack,
    input  logic            eoi,
    output logic            in_service
);

    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

    irq_state_e       state_q;
    logic [IDX_W-1:0] win_q;
    logic [IDX_W-1:0] rrPtr_q;
    logic [IDX_W-1:0] rrPtr_d;
    logic [NCH-1:0]   prev_q;
    logic             irqReq_q;
    logic [PC_W-1:0]  irqVec_q;
    logic             inService_q;

    logic [NCH-1:0]   syncIn;
    logic [NCH-1:0]   edgeDet;
    logic [NCH-1:0]   clrVec;
    logic [NCH-1:0]   eligible;
    logic [NCH-1:0]   pending_d;
    logic [NCH-1:0]   ovf_d;
    logic             ackFire;
    logic [IDX_W-1:0] arbWinner;
    logic             arbValid;
    logic [PC_W-1:0]  vecNext;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign syncIn = irq_in;
        end else begin : g_sync
            logic [NCH-1:0] sync_q [SYNC_STAGES];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= '0;
                    end
                end else begin
                    sync_q[0] <= irq_in;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign syncIn = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // A set in the ack cycle beats the clear, and does not count as overflow.
    assign edgeDet   = syncIn & ~prev_q;
    assign ackFire   = (state_q == REQ) && irq_ack;
    assign clrVec    = ackFire ? (NCH'(1) << win_q) : '0;
    assign pending_d = (pending_q & ~clrVec) | edgeDet;
    assign ovf_d     = ovf_q | (edgeDet & pending_q & ~clrVec);
    assign eligible  = pending_q & mask_q;
    assign rrPtr_d   = (win_q == IDX_W'(NCH - 1)) ? '0 : win_q + 1'b1;
    assign vecNext   = PC_W'(vecAddr(VEC_BASE, VEC_STRIDE, 32'(arbWinner)));

    cpu_irq_arb #(
        .NCH   (NCH),
        .IDX_W (IDX_W)
    ) u_arb (
        .eligible_i (eligible),
        .rrPtr_i    (rrPtr_q),
        .mode_i     (RR_MODE != 0),
        .winner_o   (arbWinner),
        .valid_o    (arbValid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            win_q       <= '0;
            rrPtr_q     <= '0;
            prev_q      <= '0;
            mask_q      <= '0;
            pending_q   <= '0;
            ovf_q       <= '0;
            irqReq_q    <= 1'b0;
            irqVec_q    <= '0;
            inService_q <= 1'b0;
        end else begin
            prev_q    <= syncIn;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            if (mask_we) begin
                mask_q <= mask_wdata;
            end
            // The winner is frozen at grant time so the vector and the
            // channel cleared on ack cannot drift while the cpu responds.
            case (state_q)
                IDLE: begin
                    if (arbValid) begin
                        win_q    <= arbWinner;
                        irqVec_q <= vecNext;
                        irqReq_q <= 1'b1;
                        state_q  <= REQ;
                    end
                end
                REQ: begin
                    if (irq_ack) begin
                        irqReq_q    <= 1'b0;
                        inService_q <= 1'b1;
                        state_q     <= SERVICE;
                        if (RR_MODE != 0) begin
                            rrPtr_q <= rrPtr_d;
                        end
                    end
                end
                SERVICE: begin
                    if (eoi) begin
                        inService_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign irq_req    = irqReq_q;
    assign irq_vec    = irqVec_q;
    assign in_service = inService_q;

endmodule

// File: tb/tb_cpu_irq_ctrl.sv
// Bench for cpu_irq_ctrl: a fixed-priority and a round-robin instance share
// stimulus and are compared against an abstract integer model of each.
module tb_cpu_irq_ctrl;

    localparam int NCH     = 4;
    localparam int VBASE   = 'h3C0;
    localparam int VSTRIDE = 4;
    localparam int PH_IDLE = 0;
    localparam int PH_REQ  = 1;
    localparam int PH_SVC  = 2;

    typedef struct {
        int mask;
        int pend;
        int ovf;
        int prev;
        int phase;
        int win;
        int vec;
        int ptr;
        int req;
        int svc;
    } model_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irqIn;
    logic       maskWe;
    logic [3:0] maskWdata;
    logic       irqAck;
    logic       eoi;

    logic [3:0] maskQ  [2];
    logic [3:0] pendQ  [2];
    logic [3:0] ovfQ   [2];
    logic       irqReq [2];
    logic [9:0] irqVec [2];
    logic       inSvc  [2];

    model_t mdl [2];
    int     cmps = 0;
    int     errs = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        cpu_irq_ctrl #(
            .NCH         (NCH),
            .PC_W        (10),
            .VEC_BASE    (32'h3C0),
            .VEC_STRIDE  (32'd4),
            .RR_MODE     (g),
            .SYNC_STAGES (0)
        ) dut (
            .clk        (clk),
            .reset      (reset),
            .irq_in     (irqIn),
            .mask_we    (maskWe),
            .mask_wdata (maskWdata),
            .mask_q     (maskQ[g]),
            .pending_q  (pendQ[g]),
            .ovf_q      (ovfQ[g]),
            .irq_req    (irqReq[g]),
            .irq_vec    (irqVec[g]),
            .irq_ack    (irqAck),
            .eoi        (eoi),
            .in_service (inSvc[g])
        );
    end

    // Reference behaviour expressed with integer bit masks and phases.
    function automatic model_t stepModel(input model_t m, input bit rr, input bit rst,
                                         input int irq, input bit we, input int wdata,
                                         input bit ack, input bit eo);
        model_t n;
        int w;
        int clr;
        int cc;
        n = m;
        if (rst) begin
            n = '{default: 0};
            return n;
        end
        w = -1;
        if (m.phase == PH_IDLE) begin
            for (int k = 0; k < NCH; k++) begin
                cc = ((rr ? m.ptr : 0) + k) % NCH;
                if (w < 0 && (((m.pend & m.mask) >> cc) & 1) == 1) w = cc;
            end
        end
        clr = (m.phase == PH_REQ && ack) ? m.win : -1;
        for (int k = 0; k < NCH; k++) begin
            if (((irq >> k) & 1) == 1 && ((m.prev >> k) & 1) == 0) begin
                if (((m.pend >> k) & 1) == 1 && k != clr) n.ovf = n.ovf | (1 << k);
                n.pend = n.pend | (1 << k);
            end else if (k == clr) begin
                n.pend = n.pend & ~(1 << k);
            end
        end
        n.prev = irq;
        if (we) n.mask = wdata;
        if (m.phase == PH_IDLE) begin
            if (w >= 0) begin
                n.win   = w;
                n.vec   = (VBASE + w * VSTRIDE) % 1024;
                n.req   = 1;
                n.phase = PH_REQ;
            end
        end else if (m.phase == PH_REQ) begin
            if (ack) begin
                n.req   = 0;
                n.svc   = 1;
                n.phase = PH_SVC;
                if (rr) n.ptr = (m.win + 1) % NCH;
            end
        end else if (eo) begin
            n.svc   = 0;
            n.phase = PH_IDLE;
        end
        return n;
    endfunction

    function automatic logic [23:0] packModel(input model_t m);
        return {4'(m.mask), 4'(m.pend), 4'(m.ovf), 1'(m.req), 10'(m.vec), 1'(m.svc)};
    endfunction

    function automatic logic [23:0] dutState(input bit g);
        return {maskQ[g], pendQ[g], ovfQ[g], irqReq[g], irqVec[g], inSvc[g]};
    endfunction

    always @(posedge clk) begin
        mdl[0] <= stepModel(mdl[0], 1'b0, reset, int'(irqIn), maskWe, int'(maskWdata), irqAck, eoi);
        mdl[1] <= stepModel(mdl[1], 1'b1, reset, int'(irqIn), maskWe, int'(maskWdata), irqAck, eoi);
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic writeMask(input logic [3:0] m);
        maskWe    = 1'b1;
        maskWdata = m;
        tick();
        maskWe    = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        for (int g = 0; g < 2; g++) begin
            cmps++;
            if (dutState(g[0]) !== 24'h0) begin
                errs++;
                $display("[TB] FAIL reset_held inst%0d: got %h, want 000000", g, dutState(g[0]));
            end
        end
        reset = 1'b0;
        tick();
        for (int g = 0; g < 2; g++) begin
            cmps++;
            if (dutState(g[0]) !== 24'h0) begin
                errs++;
                $display("[TB] FAIL reset_release inst%0d: got %h, want 000000", g, dutState(g[0]));
            end
        end
    endtask

    task automatic test_fixed_priority();
        pulseReset();
        writeMask(4'hF);
        irqIn = 4'b0110;
        tick();
        cmps++;
        if ({pendQ[0], irqReq[0]} !== {4'b0110, 1'b0}) begin
            errs++;
            $display("[TB] FAIL fp_capture: pend=%b req=%b, want pend=0110 req=0", pendQ[0], irqReq[0]);
        end
        tick();
        cmps++;
        if ({irqReq[0], irqVec[0]} !== {1'b1, 10'h3C4}) begin
            errs++;
            $display("[TB] FAIL fp_first_grant: req=%b vec=%h, want req=1 vec=3c4", irqReq[0], irqVec[0]);
        end
        irqAck = 1'b1;
        tick();
        irqAck = 1'b0;
        cmps++;
        if ({inSvc[0], irqReq[0], pendQ[0]} !== {1'b1, 1'b0, 4'b0100}) begin
            errs++;
            $display("[TB] FAIL fp_ack: svc=%b req=%b pend=%b, want svc=1 req=0 pend=0100",
                     inSvc[0], irqReq[0], pendQ[0]);
        end
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        tick();
        cmps++;
        if ({irqReq[0], irqVec[0], inSvc[0]} !== {1'b1, 10'h3C8, 1'b0}) begin
            errs++;
            $display("[TB] FAIL fp_second_grant: req=%b vec=%h svc=%b, want req=1 vec=3c8 svc=0",
                     irqReq[0], irqVec[0], inSvc[0]);
        end
        irqAck = 1'b1;
        tick();
        irqAck = 1'b0;
        eoi    = 1'b1;
        tick();
        eoi    = 1'b0;
        irqIn  = 4'b0000;
        tick();
        for (int g = 0; g < 2; g++) begin
            cmps++;
            if (dutState(g[0]) !== packModel(mdl[g[0]])) begin
                errs++;
                $display("[TB] FAIL fp_model inst%0d: dut=%h model=%h", g, dutState(g[0]), packModel(mdl[g[0]]));
            end
        end
    endtask

    task automatic test_round_robin();
        int last;
        int ch;
        int expCh;
        int budget;
        pulseReset();
        writeMask(4'hF);
        irqIn = 4'b1001;
        tick();
        irqIn = 4'b0000;
        last  = -1;
        for (int n = 0; n < 8; n++) begin
            budget = 0;
            while (irqReq[1] !== 1'b1 && budget < 20) begin
                tick();
                budget++;
            end
            cmps++;
            if (irqReq[1] !== 1'b1) begin
                errs++;
                $display("[TB] FAIL rr_wait grant%0d: req=%b, want 1 within 20 cycles", n, irqReq[1]);
            end else begin
                ch    = (int'(irqVec[1]) - VBASE) / VSTRIDE;
                expCh = (n % 2 == 0) ? 0 : 3;
                cmps++;
                if (ch != expCh || ch == last) begin
                    errs++;
                    $display("[TB] FAIL rr_grant%0d: channel=%0d, want %0d (previous %0d)", n, ch, expCh, last);
                end
                last = ch;
            end
            irqAck = 1'b1;
            tick();
            irqAck = 1'b0;
            irqIn  = 4'b1001;
            tick();
            irqIn  = 4'b0000;
            eoi    = 1'b1;
            tick();
            eoi    = 1'b0;
        end
        cmps++;
        if (dutState(1'b1) !== packModel(mdl[1])) begin
            errs++;
            $display("[TB] FAIL rr_model: dut=%h model=%h", dutState(1'b1), packModel(mdl[1]));
        end
    endtask

    task automatic test_mask_gating();
        pulseReset();
        irqIn = 4'b0010;
        tick();
        irqIn = 4'b0000;
        tick();
        cmps++;
        if ({pendQ[0], irqReq[0]} !== {4'b0010, 1'b0}) begin
            errs++;
            $display("[TB] FAIL mask_blocked: pend=%b req=%b, want pend=0010 req=0", pendQ[0], irqReq[0]);
        end
        writeMask(4'b0010);
        cmps++;
        if ({maskQ[0], irqReq[0]} !== {4'b0010, 1'b0}) begin
            errs++;
            $display("[TB] FAIL mask_write: mask=%b req=%b, want mask=0010 req=0", maskQ[0], irqReq[0]);
        end
        tick();
        cmps++;
        if ({irqReq[0], irqVec[0]} !== {1'b1, 10'h3C4}) begin
            errs++;
            $display("[TB] FAIL mask_grant: req=%b vec=%h, want req=1 vec=3c4", irqReq[0], irqVec[0]);
        end
        irqAck = 1'b1;
        tick();
        irqAck = 1'b0;
        eoi    = 1'b1;
        tick();
        eoi    = 1'b0;
    endtask

    task automatic test_overflow();
        pulseReset();
        writeMask(4'hF);
        irqIn = 4'b0100;
        tick();
        irqIn = 4'b0000;
        tick();
        cmps++;
        if ({irqReq[0], irqVec[0]} !== {1'b1, 10'h3C8}) begin
            errs++;
            $display("[TB] FAIL ovf_grant: req=%b vec=%h, want req=1 vec=3c8", irqReq[0], irqVec[0]);
        end
        irqIn  = 4'b0100;
        irqAck = 1'b1;
        tick();
        irqIn  = 4'b0000;
        irqAck = 1'b0;
        cmps++;
        if ({pendQ[0], ovfQ[0], inSvc[0]} !== {4'b0100, 4'b0000, 1'b1}) begin
            errs++;
            $display("[TB] FAIL ovf_set_beats_clear: pend=%b ovf=%b svc=%b, want pend=0100 ovf=0000 svc=1",
                     pendQ[0], ovfQ[0], inSvc[0]);
        end
        tick();
        irqIn = 4'b0100;
        tick();
        irqIn = 4'b0000;
        cmps++;
        if ({pendQ[0], ovfQ[0]} !== {4'b0100, 4'b0100}) begin
            errs++;
            $display("[TB] FAIL ovf_second_edge: pend=%b ovf=%b, want pend=0100 ovf=0100", pendQ[0], ovfQ[0]);
        end
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        tick();
        irqAck = 1'b1;
        tick();
        irqAck = 1'b0;
        eoi    = 1'b1;
        tick();
        eoi    = 1'b0;
        cmps++;
        if ({pendQ[0], ovfQ[0]} !== {4'b0000, 4'b0100}) begin
            errs++;
            $display("[TB] FAIL ovf_sticky: pend=%b ovf=%b, want pend=0000 ovf=0100", pendQ[0], ovfQ[0]);
        end
    endtask

    task automatic test_protocol_misuse();
        pulseReset();
        writeMask(4'hF);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        cmps++;
        if (dutState(1'b0) !== {4'hF, 4'h0, 4'h0, 1'b0, 10'h0, 1'b0}) begin
            errs++;
            $display("[TB] FAIL misuse_eoi_idle: got %h, want f00000", dutState(1'b0));
        end
        irqIn = 4'b0001;
        tick();
        irqIn = 4'b0000;
        tick();
        writeMask(4'h0);
        irqIn = 4'b0010;
        tick();
        irqIn = 4'b0000;
        tick();
        cmps++;
        if ({irqReq[0], irqVec[0], maskQ[0], pendQ[0]} !== {1'b1, 10'h3C0, 4'h0, 4'b0011}) begin
            errs++;
            $display("[TB] FAIL misuse_req_hold: req=%b vec=%h mask=%b pend=%b, want req=1 vec=3c0 mask=0000 pend=0011",
                     irqReq[0], irqVec[0], maskQ[0], pendQ[0]);
        end
        irqAck = 1'b1;
        tick();
        tick();
        irqAck = 1'b0;
        cmps++;
        if ({inSvc[0], irqReq[0], pendQ[0]} !== {1'b1, 1'b0, 4'b0010}) begin
            errs++;
            $display("[TB] FAIL misuse_ack_service: svc=%b req=%b pend=%b, want svc=1 req=0 pend=0010",
                     inSvc[0], irqReq[0], pendQ[0]);
        end
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        tick();
        for (int g = 0; g < 2; g++) begin
            cmps++;
            if (dutState(g[0]) !== packModel(mdl[g[0]])) begin
                errs++;
                $display("[TB] FAIL misuse_model inst%0d: dut=%h model=%h", g, dutState(g[0]), packModel(mdl[g[0]]));
            end
        end
    endtask

    task automatic test_reset_mid_service();
        pulseReset();
        writeMask(4'hF);
        irqIn = 4'b0001;
        tick();
        irqIn = 4'b0000;
        tick();
        irqAck = 1'b1;
        tick();
        irqAck = 1'b0;
        irqIn  = 4'b0100;
        tick();
        irqIn  = 4'b0000;
        reset  = 1'b1;
        tick();
        reset  = 1'b0;
        for (int g = 0; g < 2; g++) begin
            cmps++;
            if (dutState(g[0]) !== 24'h0) begin
                errs++;
                $display("[TB] FAIL rst_service inst%0d: got %h, want 000000", g, dutState(g[0]));
            end
        end
        writeMask(4'hF);
        repeat (4) tick();
        cmps++;
        if ({irqReq[0], pendQ[0], irqReq[1], pendQ[1]} !== {1'b0, 4'h0, 1'b0, 4'h0}) begin
            errs++;
            $display("[TB] FAIL rst_no_request: req0=%b pend0=%b req1=%b pend1=%b, want all zero",
                     irqReq[0], pendQ[0], irqReq[1], pendQ[1]);
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 800; cyc++) begin
            reset     = ($urandom_range(0, 99) == 0);
            irqIn     = irqIn ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            maskWe    = ($urandom_range(0, 9) == 0);
            maskWdata = 4'($urandom_range(0, 15));
            irqAck    = ($urandom_range(0, 2) == 0);
            eoi       = ($urandom_range(0, 3) == 0);
            tick();
            for (int g = 0; g < 2; g++) begin
                cmps++;
                if (dutState(g[0]) !== packModel(mdl[g[0]])) begin
                    errs++;
                    $display("[TB] FAIL random_cycle%0d inst%0d: dut=%h model=%h",
                             cyc, g, dutState(g[0]), packModel(mdl[g[0]]));
                end
            end
        end
        reset  = 1'b0;
        irqIn  = 4'b0000;
        maskWe = 1'b0;
        irqAck = 1'b0;
        eoi    = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        irqIn     = 4'b0000;
        maskWe    = 1'b0;
        maskWdata = 4'b0000;
        irqAck    = 1'b0;
        eoi       = 1'b0;
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_mask_gating();
        test_overflow();
        test_protocol_misuse();
        test_reset_mid_service();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

endmodule
